// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: line geometry, bus tag
// constants and the miss-handling state encoding.
package icache_pkg;

    localparam int unsigned LINE_BYTES = 64;
    localparam int unsigned BEATS      = 8;
    localparam int unsigned OFFSET_W   = 6;
    localparam int unsigned BEAT_W     = 3;
    localparam int unsigned REQ_TAG_W  = 13;

    localparam logic       TAG_READ   = 1'b1;
    localparam logic [3:0] TAG_MEMORY = 4'b0001;

    // Tag carried by every line-fill request: read, memory space, id 0.
    localparam logic [REQ_TAG_W-1:0] REQ_TAG = {TAG_READ, TAG_MEMORY, 8'h00};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_FILL
    } state_e;

endpackage

// File: rtl/icache_fetch_if.sv
// Request/response memory bus between the instruction cache (master) and the
// shared memory system (slave).
//   bus_reqcyc/bus_req/bus_reqtag/bus_reqack : line-fill request channel
//   bus_respcyc/bus_resp/bus_resptag/bus_respack : response beat channel
interface icache_fetch_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 13
);
    logic              bus_reqcyc;
    logic [63:0]       bus_req;
    logic [TAG_W-1:0]  bus_reqtag;
    logic              bus_reqack;
    logic              bus_respcyc;
    logic [DATA_W-1:0] bus_resp;
    logic [TAG_W-1:0]  bus_resptag;
    logic              bus_respack;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/icache_array.sv
// Direct-mapped storage: per set a valid bit, a tag and one 64-byte line.
//   clk, rst_n                      : clock, async active-low reset (valid bits only)
//   rd_idx_i, rd_beat_i             : combinational read of one 64-bit word
//   rd_valid_o, rd_tag_o, rd_word_o : read results
//   wr_en_i, wr_idx_i, wr_tag_i, wr_line_i : whole-line write, sets valid
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 64,
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned TAG_W    = 52,
    parameter int unsigned DATA_W   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IDX_W-1:0]              rd_idx_i,
    input  logic [BEAT_W-1:0]             rd_beat_i,
    output logic                          rd_valid_o,
    output logic [TAG_W-1:0]              rd_tag_o,
    output logic [DATA_W-1:0]             rd_word_o,
    input  logic                          wr_en_i,
    input  logic [IDX_W-1:0]              wr_idx_i,
    input  logic [TAG_W-1:0]              wr_tag_i,
    input  logic [BEATS-1:0][DATA_W-1:0]  wr_line_i
);

    logic [NUM_SETS-1:0]             valid_q;
    logic [TAG_W-1:0]                tag_q  [NUM_SETS];
    logic [BEATS-1:0][DATA_W-1:0]    data_q [NUM_SETS];

    // Valid bits are the only state that must be cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_line_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_word_o  = data_q[rd_idx_i][rd_beat_i];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache. Hits return the instruction at
// pc combinationally; misses fetch the 64-byte line over the bus, fill it and
// then report the hit.
//   clk, reset        : clock, async active-low reset
//   pc, stackptr      : fetch address (bits [1:0] ignored), reserved input
//   bus               : memory bus, master side
//   data_ack          : instr_reg is valid for the current pc
//   instr_reg         : instruction at pc, zero when data_ack is low
module icache_fetch
    import icache_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned NUM_SETS       = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [63:0]          pc,
    input  logic [63:0]          stackptr,
    icache_fetch_if.master       bus,
    output logic                 data_ack,
    output logic [31:0]          instr_reg
);

    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W = 64 - OFFSET_W - IDX_W;

    state_e                              state_q;
    logic [63:0]                         req_addr_q;
    logic                                reqcyc_q;
    logic [BUS_TAG_WIDTH-1:0]            reqtag_q;
    logic [BEAT_W-1:0]                   beat_q;
    logic [BEATS-1:0][BUS_DATA_WIDTH-1:0] line_q;

    logic                        rd_valid;
    logic [TAG_W-1:0]            rd_tag;
    logic [BUS_DATA_WIDTH-1:0]   rd_word;
    logic                        hit_c;
    logic                        fill_en_c;

    logic unused_ok;
    assign unused_ok = ^{stackptr, bus.bus_resptag, pc[1:0]};

    icache_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W),
        .DATA_W   (BUS_DATA_WIDTH)
    ) u_array (
        .clk        (clk),
        .rst_n      (reset),
        .rd_idx_i   (pc[OFFSET_W +: IDX_W]),
        .rd_beat_i  (pc[OFFSET_W-1 -: BEAT_W]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_word_o  (rd_word),
        .wr_en_i    (fill_en_c),
        .wr_idx_i   (req_addr_q[OFFSET_W +: IDX_W]),
        .wr_tag_i   (req_addr_q[63 -: TAG_W]),
        .wr_line_i  (line_q)
    );

    assign hit_c     = rd_valid && (rd_tag == pc[63 -: TAG_W]);
    assign fill_en_c = (state_q == ST_FILL);

    // Hits are only reported while idle so a stale line never races a fill.
    assign data_ack  = (state_q == ST_IDLE) && hit_c;
    assign instr_reg = data_ack ? (pc[2] ? rd_word[63:32] : rd_word[31:0]) : 32'h0;

    assign bus.bus_reqcyc  = reqcyc_q;
    assign bus.bus_req     = req_addr_q;
    assign bus.bus_reqtag  = reqtag_q;
    assign bus.bus_respack = (state_q == ST_RESP) && bus.bus_respcyc;

    // Miss handling: request the line, collect eight beats, then fill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            req_addr_q <= '0;
            reqcyc_q   <= 1'b0;
            reqtag_q   <= '0;
            beat_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!hit_c) begin
                        req_addr_q <= {pc[63:OFFSET_W], OFFSET_W'(0)};
                        reqcyc_q   <= 1'b1;
                        reqtag_q   <= BUS_TAG_WIDTH'(REQ_TAG);
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_reqack) begin
                        reqcyc_q <= 1'b0;
                        beat_q   <= '0;
                        state_q  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.bus_respcyc) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        if (beat_q == BEAT_W'(BEATS - 1)) begin
                            state_q <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Line buffer holds the beats until the single-cycle fill.
    always_ff @(posedge clk) begin
        if ((state_q == ST_RESP) && bus.bus_respcyc) begin
            line_q[beat_q] <= bus.bus_resp;
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
module tb_icache_fetch;

    localparam logic [12:0] EXP_REQ_TAG = 13'h1100;

    logic        clk;
    logic        reset;
    logic [63:0] pc;
    logic [63:0] stackptr;
    logic        data_ack;
    logic [31:0] instr_reg;

    int checks = 0;
    int fails  = 0;

    // Reference model: which line address each set holds and its eight words.
    bit          m_valid [64];
    logic [63:0] m_line  [64];
    logic [63:0] m_data  [64][8];

    icache_fetch_if bif ();

    icache_fetch #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .NUM_SETS       (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .stackptr  (stackptr),
        .bus       (bif),
        .data_ack  (data_ack),
        .instr_reg (instr_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int set_of(input logic [63:0] a);
        return int'(a[11:6]);
    endfunction

    function automatic bit model_hit(input logic [63:0] a);
        return m_valid[set_of(a)] && (m_line[set_of(a)] == {a[63:6], 6'b0});
    endfunction

    function automatic logic [31:0] model_instr(input logic [63:0] a);
        logic [63:0] w;
        w = m_data[set_of(a)][int'(a[5:3])];
        return a[2] ? w[63:32] : w[31:0];
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 64; s++) m_valid[s] = 1'b0;
    endtask

    // Memory-side responder: waits for the request, checks it, acks after
    // ack_dly cycles and returns beats base+i with gap idle cycles between.
    task automatic serve_miss(input logic [63:0] exp_addr, input int ack_dly, input int gap,
                              input logic [63:0] base, input bit chg, input logic [63:0] chg_pc);
        int n;
        n = 0;
        while (bif.bus_reqcyc !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bif.bus_reqcyc !== 1'b1) begin
            fails++;
            $display("FAIL req_wait: bus_reqcyc=%b, expected 1 within 40 cycles", bif.bus_reqcyc);
            return;
        end
        checks++;
        if (bif.bus_req !== exp_addr) begin
            fails++;
            $display("FAIL req_addr: got %h expected %h", bif.bus_req, exp_addr);
        end
        checks++;
        if (bif.bus_reqtag !== EXP_REQ_TAG) begin
            fails++;
            $display("FAIL req_tag: got %h expected %h", bif.bus_reqtag, EXP_REQ_TAG);
        end
        for (int d = 0; d < ack_dly; d++) begin
            @(negedge clk);
            checks++;
            if ({bif.bus_reqcyc, bif.bus_req, bif.bus_reqtag} !== {1'b1, exp_addr, EXP_REQ_TAG}) begin
                fails++;
                $display("FAIL req_stable: got cyc=%b addr=%h tag=%h expected 1/%h/%h",
                         bif.bus_reqcyc, bif.bus_req, bif.bus_reqtag, exp_addr, EXP_REQ_TAG);
            end
        end
        bif.bus_reqack = 1'b1;
        @(negedge clk);
        bif.bus_reqack = 1'b0;
        checks++;
        if (bif.bus_reqcyc !== 1'b0) begin
            fails++;
            $display("FAIL req_drop: bus_reqcyc=%b expected 0 after ack", bif.bus_reqcyc);
        end
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gap; g++) begin
                bif.bus_respcyc = 1'b0;
                #1;
                checks++;
                if (bif.bus_respack !== 1'b0) begin
                    fails++;
                    $display("FAIL respack_gap: got %b expected 0", bif.bus_respack);
                end
                @(negedge clk);
            end
            bif.bus_respcyc = 1'b1;
            bif.bus_resp    = base + 64'(i);
            #1;
            checks++;
            if (bif.bus_respack !== 1'b1) begin
                fails++;
                $display("FAIL respack_beat%0d: got %b expected 1", i, bif.bus_respack);
            end
            checks++;
            if (data_ack !== 1'b0) begin
                fails++;
                $display("FAIL busy_ack_beat%0d: data_ack=%b expected 0", i, data_ack);
            end
            if (chg && i == 4) pc = chg_pc;
            @(negedge clk);
        end
        // Fill cycle: a stray beat must not be acknowledged.
        bif.bus_resp = '0;
        #1;
        checks++;
        if (bif.bus_respack !== 1'b0) begin
            fails++;
            $display("FAIL respack_fill: got %b expected 0", bif.bus_respack);
        end
        bif.bus_respcyc = 1'b0;
        @(negedge clk);
        m_valid[set_of(exp_addr)] = 1'b1;
        m_line[set_of(exp_addr)]  = exp_addr;
        for (int i = 0; i < 8; i++) m_data[set_of(exp_addr)][i] = base + 64'(i);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pc = 64'h1000;
        repeat (2) @(negedge clk);
        checks++;
        if ({bif.bus_reqcyc, bif.bus_respack, data_ack} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000", {bif.bus_reqcyc, bif.bus_respack, data_ack});
        end
        checks++;
        if (bif.bus_req !== 64'h0) begin
            fails++;
            $display("FAIL reset_req: got %h expected 0", bif.bus_req);
        end
        checks++;
        if (bif.bus_reqtag !== 13'h0) begin
            fails++;
            $display("FAIL reset_tag: got %h expected 0", bif.bus_reqtag);
        end
        checks++;
        if (instr_reg !== 32'h0) begin
            fails++;
            $display("FAIL reset_instr: got %h expected 0", instr_reg);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bif.bus_reqcyc, data_ack} !== 2'b00) begin
            fails++;
            $display("FAIL release_idle: got %b expected 00", {bif.bus_reqcyc, data_ack});
        end
    endtask

    task automatic test_cold_miss();
        @(negedge clk);
        checks++;
        if (bif.bus_reqcyc !== 1'b1) begin
            fails++;
            $display("FAIL miss_latency: bus_reqcyc=%b expected 1 one cycle after miss", bif.bus_reqcyc);
        end
        serve_miss(64'h1000, 0, 0, 64'h1111_1111_0000_0013, 1'b0, 64'h0);
        checks++;
        if (data_ack !== 1'b1 || instr_reg !== 32'h0000_0013) begin
            fails++;
            $display("FAIL cold_hit: got ack=%b instr=%h expected 1/00000013", data_ack, instr_reg);
        end
    endtask

    task automatic test_hits();
        pc = 64'h1004;
        #1;
        checks++;
        if (data_ack !== 1'b1 || instr_reg !== 32'h1111_1111) begin
            fails++;
            $display("FAIL hit_1004: got ack=%b instr=%h expected 1/11111111", data_ack, instr_reg);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bif.bus_reqcyc !== 1'b0) begin
                fails++;
                $display("FAIL hit_quiet: bus_reqcyc=%b expected 0", bif.bus_reqcyc);
            end
        end
        pc = 64'h1038;
        #1;
        checks++;
        if (data_ack !== 1'b1 || instr_reg !== 32'h0000_001A) begin
            fails++;
            $display("FAIL hit_1038: got ack=%b instr=%h expected 1/0000001a", data_ack, instr_reg);
        end
    endtask

    task automatic test_delayed_ack();
        logic [63:0] base;
        base = {$urandom, $urandom};
        @(negedge clk);
        pc = 64'h1244;
        #1;
        checks++;
        if (data_ack !== 1'b0 || instr_reg !== 32'h0) begin
            fails++;
            $display("FAIL miss_out: got ack=%b instr=%h expected 0/00000000", data_ack, instr_reg);
        end
        serve_miss(64'h1240, 5, 2, base, 1'b0, 64'h0);
        checks++;
        if (data_ack !== 1'b1 || instr_reg !== model_instr(pc)) begin
            fails++;
            $display("FAIL delayed_hit: got ack=%b instr=%h expected 1/%h", data_ack, instr_reg, model_instr(pc));
        end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        pc = 64'h2000;
        serve_miss(64'h2000, 1, 0, {$urandom, $urandom}, 1'b0, 64'h0);
        checks++;
        if (data_ack !== 1'b1 || instr_reg !== model_instr(pc)) begin
            fails++;
            $display("FAIL conflict_2000: got ack=%b instr=%h expected 1/%h", data_ack, instr_reg, model_instr(pc));
        end
        pc = 64'h1000;
        #1;
        checks++;
        if (data_ack !== 1'b0) begin
            fails++;
            $display("FAIL conflict_evict: data_ack=%b expected 0", data_ack);
        end
        serve_miss(64'h1000, 0, 1, {$urandom, $urandom}, 1'b0, 64'h0);
        checks++;
        if (data_ack !== 1'b1 || instr_reg !== model_instr(pc)) begin
            fails++;
            $display("FAIL conflict_1000: got ack=%b instr=%h expected 1/%h", data_ack, instr_reg, model_instr(pc));
        end
    endtask

    task automatic test_pc_change();
        logic [63:0] b1000;
        @(negedge clk);
        pc = 64'h2008;
        serve_miss(64'h2000, 0, 0, {$urandom, $urandom}, 1'b0, 64'h0);
        pc = 64'h1010;
        b1000 = {$urandom, $urandom};
        serve_miss(64'h1000, 2, 1, b1000, 1'b1, 64'h3000);
        checks++;
        if (data_ack !== 1'b0) begin
            fails++;
            $display("FAIL chg_newmiss: data_ack=%b expected 0 for pc 3000", data_ack);
        end
        // Briefly look at the old line before the idle cycle ends.
        pc = 64'h1010;
        #1;
        checks++;
        if (data_ack !== 1'b1 || instr_reg !== b1000[31:0] + 32'h2) begin
            fails++;
            $display("FAIL chg_oldfill: got ack=%b instr=%h expected 1/%h", data_ack, instr_reg, b1000[31:0] + 32'h2);
        end
        pc = 64'h3000;
        serve_miss(64'h3000, 0, 0, {$urandom, $urandom}, 1'b0, 64'h0);
        checks++;
        if (data_ack !== 1'b1 || instr_reg !== model_instr(pc)) begin
            fails++;
            $display("FAIL chg_3000: got ack=%b instr=%h expected 1/%h", data_ack, instr_reg, model_instr(pc));
        end
    endtask

    task automatic test_reset_mid_miss();
        int n;
        @(negedge clk);
        pc = 64'h1000;
        n = 0;
        while (bif.bus_reqcyc !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        bif.bus_reqack = 1'b1;
        @(negedge clk);
        bif.bus_reqack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bif.bus_respcyc = 1'b1;
            bif.bus_resp    = 64'hDEAD_0000 + 64'(i);
            @(negedge clk);
        end
        bif.bus_resp = 64'hDEAD_0004;
        reset = 1'b0;
        #1;
        checks++;
        if ({bif.bus_reqcyc, bif.bus_respack, data_ack, instr_reg, bif.bus_req, bif.bus_reqtag} !== '0) begin
            fails++;
            $display("FAIL midreset_outs: cyc=%b rack=%b ack=%b instr=%h req=%h tag=%h expected all 0",
                     bif.bus_reqcyc, bif.bus_respack, data_ack, instr_reg, bif.bus_req, bif.bus_reqtag);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        pc = 64'h3000;
        #1;
        checks++;
        if (bif.bus_respack !== 1'b0) begin
            fails++;
            $display("FAIL midreset_beats: bus_respack=%b expected 0", bif.bus_respack);
        end
        checks++;
        if (data_ack !== 1'b0) begin
            fails++;
            $display("FAIL midreset_stale: data_ack=%b expected 0", data_ack);
        end
        bif.bus_respcyc = 1'b0;
        pc = 64'h1000;
        serve_miss(64'h1000, 0, 0, 64'h1111_1111_0000_0013, 1'b0, 64'h0);
        checks++;
        if (data_ack !== 1'b1 || instr_reg !== 32'h0000_0013) begin
            fails++;
            $display("FAIL midreset_refill: got ack=%b instr=%h expected 1/00000013", data_ack, instr_reg);
        end
    endtask

    task automatic test_random();
        logic [63:0] line;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            line = (64'($urandom_range(1, 3)) << 12) | (64'($urandom_range(0, 3)) << 6);
            pc = line | (64'($urandom_range(0, 15)) << 2) | 64'($urandom_range(0, 3));
            stackptr = {$urandom, $urandom};
            #1;
            if (model_hit(pc)) begin
                checks++;
                if (data_ack !== 1'b1 || instr_reg !== model_instr(pc)) begin
                    fails++;
                    $display("FAIL rnd_hit pc=%h: got ack=%b instr=%h expected 1/%h", pc, data_ack, instr_reg, model_instr(pc));
                end
            end else begin
                checks++;
                if (data_ack !== 1'b0 || instr_reg !== 32'h0) begin
                    fails++;
                    $display("FAIL rnd_miss pc=%h: got ack=%b instr=%h expected 0/00000000", pc, data_ack, instr_reg);
                end
                serve_miss(line, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                           {$urandom, $urandom}, 1'b0, 64'h0);
                checks++;
                if (data_ack !== 1'b1 || instr_reg !== model_instr(pc)) begin
                    fails++;
                    $display("FAIL rnd_fill pc=%h: got ack=%b instr=%h expected 1/%h", pc, data_ack, instr_reg, model_instr(pc));
                end
            end
        end
    endtask

    initial begin
        reset           = 1'b0;
        pc              = 64'h0;
        stackptr        = 64'h0;
        bif.bus_reqack  = 1'b0;
        bif.bus_respcyc = 1'b0;
        bif.bus_resp    = '0;
        bif.bus_resptag = '0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_hits();
        test_delayed_ack();
        test_conflict();
        test_pc_change();
        test_reset_mid_miss();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
